// File: rtl/seg_msg_arbiter.sv
// Seven-segment message arbiter: shares one 8-digit frame between an alert
// source (0), a notice source (1) and a live background banner (2). Sources
// 0 and 1 post one-shot frames that are latched and held for a fixed time;
// source 0 pre-empts source 1, and the banner shows whenever nothing is held.
module seg_msg_arbiter #(
  parameter int TICK_DIV   = 100000,  // clk cycles per hold tick, >= 2
  parameter int HOLD_TICKS = 1000     // hold length in ticks, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic [63:0] frame_out,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HC_W  = $clog2(HOLD_TICKS + 1);

  // Owner encoding doubles as the FSM state: 0/1 are HOLD, 2/3 are IDLE.
  typedef enum logic [1:0] {
    OWN_ALERT  = 2'd0,
    OWN_NOTICE = 2'd1,
    OWN_BANNER = 2'd2,
    OWN_NONE   = 2'd3
  } owner_e;

  owner_e            owner_q;
  logic [1:0]        pend;
  logic [63:0]       buf0;
  logic [63:0]       buf1;
  logic [PSC_W-1:0]  psc;
  logic [HC_W-1:0]   hold_cnt;

  logic              hold_active;
  logic              psc_wrap;
  logic              expire;
  logic              restart;
  logic [1:0]        pend_nx;
  logic [63:0]       buf0_nx;
  logic [63:0]       buf1_nx;
  owner_e            owner_nx;
  logic [63:0]       frame_nx;
  logic [2:0]        done_nx;

  assign owner = owner_q;

  // Next-state selection: latching, expiry, priority and the displayed frame.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    hold_active = ~owner_q[1];
    psc_wrap    = (psc == PSC_W'(TICK_DIV - 1));
    // A request from the owner in its last cycle refreshes instead of expiring.
    expire      = hold_active && psc_wrap && (hold_cnt == HC_W'(1)) && !req[owner_q[0]];
    done_nx     = 3'b000;
    pend_nx     = pend;
    if (expire) begin
      done_nx[owner_q[0]] = 1'b1;
      pend_nx[owner_q[0]] = 1'b0;
    end
    pend_nx = pend_nx | req[1:0];
    buf0_nx = req[0] ? frame0 : buf0;
    buf1_nx = req[1] ? frame1 : buf1;

    if (pend_nx[0])      owner_nx = OWN_ALERT;
    else if (pend_nx[1]) owner_nx = OWN_NOTICE;
    else if (req[2])     owner_nx = OWN_BANNER;
    else                 owner_nx = OWN_NONE;

    // Fresh hold when a held source takes over, or its owner re-requests.
    restart = !owner_nx[1] && ((owner_nx != owner_q) || req[owner_nx[0]]);

    frame_nx = 64'h0;
    case (owner_nx)
      OWN_ALERT:  frame_nx = buf0_nx;
      OWN_NOTICE: frame_nx = buf1_nx;
      OWN_BANNER: frame_nx = frame2;
      default:    frame_nx = 64'h0;
    endcase
  end

  // Registered outputs, pending flags, frame buffers and hold timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the frame buffers are plain registers, cheap enough to clear on reset.
      ack       <= 3'b000;
      done      <= 3'b000;
      frame_out <= 64'h0;
      owner_q   <= OWN_NONE;
      busy      <= 1'b0;
      pend      <= 2'b00;
      buf0      <= 64'h0;
      buf1      <= 64'h0;
      psc       <= '0;
      hold_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      ack       <= {1'b0, req[1:0]};
      done      <= done_nx;
      frame_out <= frame_nx;
      owner_q   <= owner_nx;
      busy      <= !owner_nx[1];
      pend      <= pend_nx;
      buf0      <= buf0_nx;
      buf1      <= buf1_nx;
      if (restart) begin
        psc      <= '0;
        hold_cnt <= HC_W'(HOLD_TICKS);
      end else if (!owner_nx[1]) begin
        if (psc_wrap) begin
          psc      <= '0;
          hold_cnt <= hold_cnt - 1'b1;
        end else begin
          psc <= psc + 1'b1;
        end
      end else begin
        psc      <= '0;
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_msg_arbiter.sv
// Scoreboard bench for seg_msg_arbiter with TICK_DIV = 4, HOLD_TICKS = 3
// (12-cycle holds). Each test pushes its hand-computed expected events and
// probe points, then drives stimulus; the monitor compares on every pulse
// and every probe cycle, flagging any pulse nobody expected.
module tb_seg_msg_arbiter;

  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 3;

  localparam logic [63:0] ERR  = 64'h7950_5000_0000_0000;
  localparam logic [63:0] DISP = 64'h5E10_6D73_0000_0000;
  localparam logic [63:0] NUMS = 64'h0000_0000_3F06_5B4F;
  localparam logic [63:0] F0   = 64'h0F0F_1234_5678_0F0F;
  localparam logic [63:0] F0B  = 64'hA5A5_0000_FFFF_5A5A;
  localparam logic [63:0] F1   = 64'h1111_2222_3333_4444;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [63:0] frame0 = 64'h0;
  logic [63:0] frame1 = 64'h0;
  logic [63:0] frame2 = 64'h0;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic [63:0] frame_out;
  logic [1:0]  owner;
  logic        busy;

  seg_msg_arbiter #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clk(clk), .rst(rst), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2),
    .ack(ack), .done(done), .frame_out(frame_out), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  ack;
    logic [2:0]  done;
    logic [1:0]  owner;
    logic [63:0] frame;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   base   = 0;
  bit   armed  = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at rel cycle %0d: got %h want %h", name, cyc - base, act, want);
    end
  endtask

  task automatic expect_at(int rel, logic [2:0] a, logic [2:0] d, logic [1:0] o, logic [63:0] f);
    exp_t x;
    x.cyc = base + rel; x.ack = a; x.done = d; x.owner = o; x.frame = f;
    sb.push_back(x);
  endtask

  task automatic go_to(int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_test();
    @(posedge clk); #1;
    rst = 1'b1; req = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
    base = cyc;
    armed = 1'b1;
  endtask

  // Monitor: compare whenever the DUT pulses or a probe cycle comes up.
  always @(negedge clk) begin
    if (armed && ((sb.size() > 0 && sb[0].cyc == cyc) || ack != 3'b000 || done != 3'b000)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {58'b0, done, ack}, 64'h0);
      end else begin
        e = sb.pop_front();
        check("event_cycle", 64'(cyc - base), 64'(e.cyc - base));
        check("ack",   {61'b0, ack},   {61'b0, e.ack});
        check("done",  {61'b0, done},  {61'b0, e.done});
        check("owner", {62'b0, owner}, {62'b0, e.owner});
        check("busy",  {63'b0, busy},  {63'b0, (e.owner < 2'd2)});
        check("frame", frame_out, e.frame);
      end
    end
  end

  initial begin
    // Basic hold of a one-cycle notice request.
    start_test();
    expect_at(0,  3'b000, 3'b000, 2'd3, 64'h0);
    expect_at(11, 3'b010, 3'b000, 2'd1, ERR);
    expect_at(16, 3'b000, 3'b000, 2'd1, ERR);
    expect_at(22, 3'b000, 3'b000, 2'd1, ERR);
    expect_at(23, 3'b000, 3'b010, 2'd3, 64'h0);
    expect_at(30, 3'b000, 3'b000, 2'd3, 64'h0);
    go_to(10); frame1 = ERR; req = 3'b010;
    go_to(11); req = 3'b000; frame1 = 64'h0;
    go_to(32);

    // Live background banner follows frame2 one cycle late.
    start_test();
    expect_at(6,  3'b000, 3'b000, 2'd2, DISP);
    expect_at(20, 3'b000, 3'b000, 2'd2, DISP);
    expect_at(30, 3'b000, 3'b000, 2'd2, DISP);
    expect_at(31, 3'b000, 3'b000, 2'd2, NUMS);
    expect_at(36, 3'b000, 3'b000, 2'd3, 64'h0);
    go_to(5);  frame2 = DISP; req = 3'b100;
    go_to(30); frame2 = NUMS;
    go_to(35); req = 3'b000;
    go_to(40);

    // Pre-emption of a notice by an alert; notice resumes with a full hold.
    start_test();
    expect_at(11, 3'b010, 3'b000, 2'd1, F1);
    expect_at(16, 3'b001, 3'b000, 2'd0, F0);
    expect_at(27, 3'b000, 3'b000, 2'd0, F0);
    expect_at(28, 3'b000, 3'b001, 2'd1, F1);
    expect_at(39, 3'b000, 3'b000, 2'd1, F1);
    expect_at(40, 3'b000, 3'b010, 2'd3, 64'h0);
    go_to(10); frame1 = F1; req = 3'b010;
    go_to(11); frame1 = 64'h0; req = 3'b000;
    go_to(15); frame0 = F0; req = 3'b001;
    go_to(16); frame0 = 64'h0; req = 3'b000;
    go_to(50);

    // Simultaneous requests, then an alert refresh in its expiry cycle.
    start_test();
    expect_at(11, 3'b011, 3'b000, 2'd0, F0);
    expect_at(22, 3'b000, 3'b000, 2'd0, F0);
    expect_at(23, 3'b001, 3'b000, 2'd0, F0B);
    expect_at(34, 3'b000, 3'b000, 2'd0, F0B);
    expect_at(35, 3'b000, 3'b001, 2'd1, F1);
    expect_at(46, 3'b000, 3'b000, 2'd1, F1);
    expect_at(47, 3'b000, 3'b010, 2'd3, 64'h0);
    go_to(10); frame0 = F0; frame1 = F1; req = 3'b011;
    go_to(11); frame1 = 64'h0; req = 3'b000;
    go_to(22); frame0 = F0B; req = 3'b001;
    go_to(23); frame0 = 64'h0; req = 3'b000;
    go_to(55);

    // Alert request held for 50 cycles: ack every cycle, done 12 after the last.
    start_test();
    for (int r = 11; r <= 60; r++) expect_at(r, 3'b001, 3'b000, 2'd0, F0);
    expect_at(71, 3'b000, 3'b000, 2'd0, F0);
    expect_at(72, 3'b000, 3'b001, 2'd3, 64'h0);
    go_to(10); frame0 = F0; req = 3'b001;
    go_to(60); req = 3'b000;
    go_to(80);

    // Reset mid-hold with a second source pending clears everything.
    start_test();
    expect_at(11, 3'b010, 3'b000, 2'd1, F1);
    expect_at(16, 3'b001, 3'b000, 2'd0, F0);
    expect_at(18, 3'b000, 3'b000, 2'd0, F0);
    expect_at(19, 3'b000, 3'b000, 2'd3, 64'h0);
    expect_at(28, 3'b000, 3'b000, 2'd3, 64'h0);
    expect_at(40, 3'b000, 3'b000, 2'd3, 64'h0);
    go_to(10); frame1 = F1; req = 3'b010;
    go_to(11); req = 3'b000;
    go_to(15); frame0 = F0; req = 3'b001;
    go_to(16); req = 3'b000;
    go_to(18); rst = 1'b1;
    go_to(19); rst = 1'b0;
    go_to(50);

    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
